sdram_arbiter: RTL and testbench

Command arbiter that sits directly downstream of `sdram_init`, `sdram_aref`, `sdram_write` and `sdram_read`. It grants the SDRAM command bus to one requester at a time, with fixed priority refresh > write > read, and drives the chip pins. It replaces the ad-hoc init/read command mux used in block-level benches and is the sole driver of the SDRAM command, address and data pins.

---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_arbiter_if.sv | 52 +++++
 rtl/sdram_arbiter.sv | 98 +++++++++
 tb/tb_sdram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: arbiter states, pin commands and bus widths.
// Used by the arbiter and by the init, aref, write and read blocks.
// No logic here.
package sdram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int BA_W   = 2;

    // Command encoding is {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } sdram_bus_t;

    // Idle pin pattern: NOP with bank and address parked high
    function automatic sdram_bus_t nop_bus();
        sdram_bus_t b;
        b.cmd  = CMD_NOP;
        b.ba   = '1;
        b.addr = '1;
        return b;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side bundle of the SDRAM arbiter: four command buses, write data,
// request/end handshakes and the grants returned to each requester.
// master = requester side, slave = arbiter side.
interface sdram_arbiter_if;
    import sdram_pkg::*;

    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_data;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;

    logic              aref_en;
    logic              wr_en;
    logic              rd_en;

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en
    );

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en
    );

endinterface

// File: rtl/sdram_arbiter.sv
// Fixed-priority SDRAM command arbiter (refresh > write > read); sole driver of the chip pins.
// Latency: grant one cycle after a request is sampled in ARBIT; at least one NOP cycle between grants.
// Backpressure: requests are not queued, requesters hold *_req until their *_en rises.
module sdram_arbiter
    import sdram_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    sdram_arbiter_if.slave    ctrl,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    arb_state_t state;
    sdram_bus_t pin_bus;
    logic       dq_oe;

    // Grants are registered alongside the state so they always equal state decode
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= INIT;
            ctrl.aref_en <= 1'b0;
            ctrl.wr_en   <= 1'b0;
            ctrl.rd_en   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (ctrl.init_end) begin
                        state <= ARBIT;
                    end
                end
                ARBIT: begin
                    if (ctrl.aref_req) begin
                        state        <= AREF;
                        ctrl.aref_en <= 1'b1;
                    end else if (ctrl.wr_req) begin
                        state       <= WRITE;
                        ctrl.wr_en  <= 1'b1;
                    end else if (ctrl.rd_req) begin
                        state       <= READ;
                        ctrl.rd_en  <= 1'b1;
                    end
                end
                AREF: begin
                    if (ctrl.aref_end) begin
                        state        <= ARBIT;
                        ctrl.aref_en <= 1'b0;
                    end
                end
                WRITE: begin
                    if (ctrl.wr_end) begin
                        state      <= ARBIT;
                        ctrl.wr_en <= 1'b0;
                    end
                end
                READ: begin
                    if (ctrl.rd_end) begin
                        state      <= ARBIT;
                        ctrl.rd_en <= 1'b0;
                    end
                end
                default: begin
                    state        <= INIT;
                    ctrl.aref_en <= 1'b0;
                    ctrl.wr_en   <= 1'b0;
                    ctrl.rd_en   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pin_bus = nop_bus();
        case (state)
            INIT:    pin_bus = '{ctrl.init_cmd, ctrl.init_ba, ctrl.init_addr};
            AREF:    pin_bus = '{ctrl.aref_cmd, ctrl.aref_ba, ctrl.aref_addr};
            WRITE:   pin_bus = '{ctrl.wr_cmd,   ctrl.wr_ba,   ctrl.wr_addr};
            READ:    pin_bus = '{ctrl.rd_cmd,   ctrl.rd_ba,   ctrl.rd_addr};
            default: pin_bus = nop_bus();
        endcase
    end

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_bus.cmd;
    assign sdram_ba   = pin_bus.ba;
    assign sdram_addr = pin_bus.addr;

    // Reads sample sdram_dq directly, so the arbiter only ever drives it for writes
    assign dq_oe    = (state == WRITE) && ctrl.wr_sdram_en;
    assign sdram_dq = dq_oe ? ctrl.wr_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; a weak-side bench driver puts
// 16'h5A5A on DQ whenever the arbiter is expected to have released the bus.
module tb_sdram_arbiter;

    logic        sys_clk;
    logic        sys_rst;
    logic        sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    wire  [15:0] sdram_dq;
    logic        tb_dq_en;

    int n_checks;
    int n_fail;

    localparam logic [17:0] PINS_INIT = {4'b0010, 2'b01, 12'h400};
    localparam logic [17:0] PINS_NOP  = {4'b0111, 2'b11, 12'hfff};
    localparam logic [17:0] PINS_AREF = {4'b0001, 2'b00, 12'h0a0};
    localparam logic [17:0] PINS_WR   = {4'b0100, 2'b10, 12'h123};
    localparam logic [17:0] PINS_RD   = {4'b0101, 2'b01, 12'h001};
    localparam logic [15:0] DQ_PULL   = 16'h5A5A;
    localparam logic [15:0] DQ_WR     = 16'hA5A5;

    sdram_arbiter_if u_if ();

    sdram_arbiter u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .ctrl        (u_if.slave),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .sdram_dq    (sdram_dq)
    );

    assign sdram_dq = tb_dq_en ? DQ_PULL : 16'hzzzz;

    logic [17:0] pins;
    logic [2:0]  grants;
    assign pins   = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
    assign grants = {u_if.aref_en, u_if.wr_en, u_if.rd_en};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        n_checks++;
        if (grants !== 3'b000) begin n_fail++; $display("FAIL reset_grants got %b exp 000", grants); end
        n_checks++;
        if (sdram_cke !== 1'b1) begin n_fail++; $display("FAIL reset_cke got %b exp 1", sdram_cke); end
        n_checks++;
        if (pins !== PINS_INIT) begin n_fail++; $display("FAIL reset_pins got %h exp %h", pins, PINS_INIT); end
        sys_rst  = 1'b0;
        tb_dq_en = 1'b1;
        #1;
        n_checks++;
        if (sdram_dq !== DQ_PULL) begin n_fail++; $display("FAIL reset_dq_released got %h exp %h", sdram_dq, DQ_PULL); end
        tick();
        n_checks++;
        if (pins !== PINS_INIT) begin n_fail++; $display("FAIL init_hold_pins got %h exp %h", pins, PINS_INIT); end
        u_if.init_end = 1'b1;
        tick();
        n_checks++;
        if (pins !== PINS_NOP) begin n_fail++; $display("FAIL init_to_arbit_pins got %h exp %h", pins, PINS_NOP); end
        n_checks++;
        if (grants !== 3'b000) begin n_fail++; $display("FAIL arbit_grants got %b exp 000", grants); end
    endtask

    task automatic test_read();
        u_if.wr_end = 1'b1;
        tick();
        u_if.wr_end = 1'b0;
        n_checks++;
        if (pins !== PINS_NOP) begin n_fail++; $display("FAIL stray_end_in_arbit got %h exp %h", pins, PINS_NOP); end
        u_if.rd_req = 1'b1;
        tick();
        u_if.rd_req = 1'b0;
        n_checks++;
        if (grants !== 3'b001) begin n_fail++; $display("FAIL read_grant got %b exp 001", grants); end
        n_checks++;
        if (pins !== PINS_RD) begin n_fail++; $display("FAIL read_pins got %h exp %h", pins, PINS_RD); end
        n_checks++;
        if (sdram_dq !== DQ_PULL) begin n_fail++; $display("FAIL read_dq_released got %h exp %h", sdram_dq, DQ_PULL); end
        tick();
        n_checks++;
        if (grants !== 3'b001) begin n_fail++; $display("FAIL read_hold got %b exp 001", grants); end
        u_if.rd_end = 1'b1;
        tick();
        u_if.rd_end = 1'b0;
        n_checks++;
        if (grants !== 3'b000) begin n_fail++; $display("FAIL read_release got %b exp 000", grants); end
        n_checks++;
        if (pins !== PINS_NOP) begin n_fail++; $display("FAIL read_release_nop got %h exp %h", pins, PINS_NOP); end
        tick();
        n_checks++;
        if (pins !== PINS_NOP) begin n_fail++; $display("FAIL idle_nop got %h exp %h", pins, PINS_NOP); end
    endtask

    task automatic test_priority();
        u_if.aref_req = 1'b1;
        u_if.wr_req   = 1'b1;
        u_if.rd_req   = 1'b1;
        tick();
        u_if.aref_req = 1'b0;
        n_checks++;
        if (grants !== 3'b100 || pins !== PINS_AREF) begin
            n_fail++; $display("FAIL prio_aref got grants %b pins %h exp 100 %h", grants, pins, PINS_AREF);
        end
        u_if.aref_end = 1'b1;
        tick();
        u_if.aref_end = 1'b0;
        n_checks++;
        if (grants !== 3'b000 || pins !== PINS_NOP) begin
            n_fail++; $display("FAIL prio_gap1 got grants %b pins %h exp 000 %h", grants, pins, PINS_NOP);
        end
        tick();
        u_if.wr_req = 1'b0;
        n_checks++;
        if (grants !== 3'b010 || pins !== PINS_WR) begin
            n_fail++; $display("FAIL prio_write got grants %b pins %h exp 010 %h", grants, pins, PINS_WR);
        end
        u_if.wr_end = 1'b1;
        tick();
        u_if.wr_end = 1'b0;
        n_checks++;
        if (grants !== 3'b000 || pins !== PINS_NOP) begin
            n_fail++; $display("FAIL prio_gap2 got grants %b pins %h exp 000 %h", grants, pins, PINS_NOP);
        end
        tick();
        u_if.rd_req = 1'b0;
        n_checks++;
        if (grants !== 3'b001 || pins !== PINS_RD) begin
            n_fail++; $display("FAIL prio_read got grants %b pins %h exp 001 %h", grants, pins, PINS_RD);
        end
        u_if.rd_end = 1'b1;
        tick();
        u_if.rd_end = 1'b0;
        n_checks++;
        if (grants !== 3'b000) begin n_fail++; $display("FAIL prio_done got %b exp 000", grants); end
    endtask

    task automatic test_write_dq();
        u_if.wr_req      = 1'b1;
        u_if.wr_data     = DQ_WR;
        u_if.wr_sdram_en = 1'b0;
        tick();
        u_if.wr_req = 1'b0;
        n_checks++;
        if (sdram_dq !== DQ_PULL) begin n_fail++; $display("FAIL wr_dq_off got %h exp %h", sdram_dq, DQ_PULL); end
        tb_dq_en         = 1'b0;
        u_if.wr_sdram_en = 1'b1;
        #1;
        n_checks++;
        if (sdram_dq !== DQ_WR) begin n_fail++; $display("FAIL wr_dq_drive got %h exp %h", sdram_dq, DQ_WR); end
        u_if.wr_sdram_en = 1'b0;
        tb_dq_en         = 1'b1;
        u_if.wr_end      = 1'b1;
        tick();
        u_if.wr_end      = 1'b0;
        u_if.wr_sdram_en = 1'b1;
        #1;
        n_checks++;
        if (sdram_dq !== DQ_PULL) begin n_fail++; $display("FAIL arbit_dq_released got %h exp %h", sdram_dq, DQ_PULL); end
        u_if.wr_sdram_en = 1'b0;
    endtask

    task automatic test_aref_during_read();
        u_if.rd_req = 1'b1;
        tick();
        u_if.rd_req   = 1'b0;
        u_if.aref_req = 1'b1;
        u_if.wr_req   = 1'b1;
        tick();
        n_checks++;
        if (grants !== 3'b001) begin n_fail++; $display("FAIL no_preempt got %b exp 001", grants); end
        u_if.rd_end = 1'b1;
        tick();
        u_if.rd_end = 1'b0;
        n_checks++;
        if (grants !== 3'b000 || pins !== PINS_NOP) begin
            n_fail++; $display("FAIL end_with_pending got grants %b pins %h exp 000 %h", grants, pins, PINS_NOP);
        end
        tick();
        u_if.aref_req = 1'b0;
        n_checks++;
        if (grants !== 3'b100) begin n_fail++; $display("FAIL aref_ahead_of_wr got %b exp 100", grants); end
        u_if.aref_end = 1'b1;
        tick();
        u_if.aref_end = 1'b0;
        tick();
        u_if.wr_req = 1'b0;
        n_checks++;
        if (grants !== 3'b010) begin n_fail++; $display("FAIL pending_wr_grant got %b exp 010", grants); end
    endtask

    task automatic test_reset_mid_write();
        tb_dq_en         = 1'b0;
        u_if.wr_sdram_en = 1'b1;
        #1;
        n_checks++;
        if (sdram_dq !== DQ_WR) begin n_fail++; $display("FAIL pre_reset_dq got %h exp %h", sdram_dq, DQ_WR); end
        #2;
        sys_rst  = 1'b1;
        tb_dq_en = 1'b1;
        #1;
        n_checks++;
        if (grants !== 3'b000) begin n_fail++; $display("FAIL async_rst_grants got %b exp 000", grants); end
        n_checks++;
        if (sdram_dq !== DQ_PULL) begin n_fail++; $display("FAIL async_rst_dq got %h exp %h", sdram_dq, DQ_PULL); end
        n_checks++;
        if (pins !== PINS_INIT) begin n_fail++; $display("FAIL async_rst_pins got %h exp %h", pins, PINS_INIT); end
        u_if.init_end = 1'b0;
        tick();
        sys_rst     = 1'b0;
        u_if.wr_end = 1'b1;
        tick();
        u_if.wr_end = 1'b0;
        n_checks++;
        if (grants !== 3'b000 || pins !== PINS_INIT) begin
            n_fail++; $display("FAIL stray_wr_end got grants %b pins %h exp 000 %h", grants, pins, PINS_INIT);
        end
        n_checks++;
        if (sdram_dq !== DQ_PULL) begin n_fail++; $display("FAIL init_dq got %h exp %h", sdram_dq, DQ_PULL); end
        u_if.wr_sdram_en = 1'b0;
        u_if.init_end    = 1'b1;
        tick();
        u_if.init_end = 1'b0;
        tick();
        n_checks++;
        if (pins !== PINS_NOP) begin n_fail++; $display("FAIL init_end_drop_ignored got %h exp %h", pins, PINS_NOP); end
        u_if.rd_req = 1'b1;
        tick();
        u_if.rd_req = 1'b0;
        n_checks++;
        if (grants !== 3'b001) begin n_fail++; $display("FAIL post_reset_read got %b exp 001", grants); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sys_rst  = 1'b1;
        tb_dq_en = 1'b0;
        u_if.init_end    = 1'b0;
        u_if.init_cmd    = 4'b0010;
        u_if.init_ba     = 2'b01;
        u_if.init_addr   = 12'h400;
        u_if.aref_req    = 1'b0;
        u_if.aref_end    = 1'b0;
        u_if.aref_cmd    = 4'b0001;
        u_if.aref_ba     = 2'b00;
        u_if.aref_addr   = 12'h0a0;
        u_if.wr_req      = 1'b0;
        u_if.wr_end      = 1'b0;
        u_if.wr_cmd      = 4'b0100;
        u_if.wr_ba       = 2'b10;
        u_if.wr_addr     = 12'h123;
        u_if.wr_sdram_en = 1'b0;
        u_if.wr_data     = DQ_WR;
        u_if.rd_req      = 1'b0;
        u_if.rd_end      = 1'b0;
        u_if.rd_cmd      = 4'b0101;
        u_if.rd_ba       = 2'b01;
        u_if.rd_addr     = 12'h001;

        test_reset();
        test_read();
        test_priority();
        test_write_dq();
        test_aref_during_read();
        test_reset_mid_write();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
